eth_rx_axis_packer: RTL and testbench
=====================================

Name: eth_rx_axis_packer

Overview:
- Upstream stage of the Ethernet receive buffer.
- Accepts the 1G MAC's byte-wide AXIS receive stream and packs it into data_width_p-wide AXIS words, with tkeep, tlast and tuser, in the form the receive buffer consumes.
- Enforces a maximum frame length by truncating oversize frames and flagging them bad.
- Counts errored frames.

Parameters:
- data_width_p, 32, output word width in bits; 32 or 64 only.
- max_frame_p, 2048, maximum frame length in bytes, >= 1.
- err_count_width_p, 16, width of the saturating error-frame counter.

Ports:
- clk_i  input  1  clock
- reset_n_i  input  1  asynchronous active-low reset
- s_axis_tdata_i  input  8  byte from MAC
- s_axis_tvalid_i  input  1  byte valid
- s_axis_tready_o  output  1  byte accepted when high with tvalid
- s_axis_tlast_i  input  1  last byte of frame
- s_axis_tuser_i  input  1  byte/frame error from MAC
- m_axis_tdata_o  output  data_width_p  packed word
- m_axis_tkeep_o  output  data_width_p/8  valid byte lanes
- m_axis_tvalid_o  output  1  word valid
- m_axis_tready_i  input  1  downstream ready
- m_axis_tlast_o  output  1  last word of frame
- m_axis_tuser_o  output  1  frame bad; meaningful only with tlast
- err_count_o  output  err_count_width_p  frames emitted with tuser=1; saturates at all-ones

Behaviour:
- Reset:
  - Reset is asynchronous and active-low.
  - While reset_n_i=0: all m_axis_* outputs, s_axis_tready_o and err_count_o are 0; the byte index, frame byte count, sticky error flag, asm_full and out_valid are all cleared; state is ACCUM.
  - Reset asserted mid-frame discards all partial state. The first byte after release is treated as byte 0 of a new frame.
- Definitions:
  - N = data_width_p/8.
  - Byte lanes are little-endian: frame byte k of a word goes to lane k mod N, bits [8(k mod N)+7 : 8(k mod N)].
  - Unused lanes carry zero data.
  - tkeep is contiguous from lane 0 and equals (1<<nbytes)-1.
- Storage:
  - Assembly register: partial word, byte index 0..N-1, asm_full flag.
  - Output register: out_valid.
- State ACCUM:
  - s_axis_tready_o = ~asm_full.
  - On each accepted byte: write the lane, OR s_axis_tuser_i into the sticky error flag, increment the frame byte count.
  - The word completes when byte index = N-1, or tlast=1, or the frame count reaches max_frame_p.
- Word completion handoff:
  - If the output register is free this cycle (~out_valid, or m_axis_tready_i=1), the completed word loads into the output register. m_axis_tvalid_o rises the next cycle (latency 1 from the completing byte).
  - Otherwise asm_full is set and the input stalls.
- asm_full drain: when asm_full=1 and the output register frees, the assembly contents move to the output register and asm_full clears in the same edge.
- Full-rate operation: one byte per cycle is sustained when m_axis_tready_i=1.
- End of frame (byte with tlast):
  - Word is tagged tlast=1, tuser = sticky flag.
  - Byte index, frame count and sticky flag reset for the next frame.
- Truncation:
  - Applies when byte number max_frame_p (count = max_frame_p-1 before accept) is accepted with tlast=0.
  - That byte ends the emitted frame with tlast=1, tuser=1. State moves to DISCARD.
  - If that byte has tlast=1, the frame is normal.
- State DISCARD:
  - s_axis_tready_o = 1.
  - Bytes are consumed and dropped. The output side keeps draining.
  - The byte with tlast returns state to ACCUM; nothing from it is emitted.
- Output handshake:
  - Standard AXIS: the word holds stable while tvalid=1 and tready=0.
  - out_valid clears on a handshake unless a new word loads in the same edge.
- err_count_o increments by 1 on each handshake of a word with tlast=1 and tuser=1, saturating at all-ones.
- m_axis_tuser_o is 0 on non-last words.

Test Plan:
- data_width_p=32, 9-byte frame 0x01..0x09, m_tready=1 -> three words:
  - 0x04030201 keep 0xF
  - 0x08070605 keep 0xF
  - 0x00000009 keep 0x1, tlast=1, tuser=0
  - first tvalid one cycle after byte 4
- 8-byte frame with m_tready held 0 -> first word in output register, second in assembly; s_tready drops after byte 8. Release m_tready -> 0x04030201 then 0x08070605 (tlast), no loss or reorder.
- 6-byte frame with s_tuser=1 on byte 3 only -> second word keep 0x3, tlast=1, tuser=1; err_count_o 0->1.
- max_frame_p=16, 20-byte frame then a 5-byte frame -> four words, the last with keep 0xF, tlast=1, tuser=1; bytes 17-20 accepted and dropped. Next frame emits 2 words, the last keep 0x1, tuser=0; err_count_o = 1.
- reset_n_i pulsed low after byte 3 of a frame -> m_axis_tvalid_o and s_axis_tready_o go 0 immediately. After release, frame 0xA1..0xA4 emits 0xA4A3A2A1 keep 0xF tlast.
- data_width_p=64, 1-byte frame 0x5A -> one word 0x000000000000005A, keep 0x01, tlast=1, tuser=0.

Source files
------------

// File: rtl/eth_rx_axis_packer.sv
// Packs the MAC's byte-wide AXIS receive stream into data_width_p-wide AXIS words.
// Oversize frames are truncated and flagged bad, and bad frames are counted.
module eth_rx_axis_packer #(
  parameter int data_width_p      = 32,
  parameter int max_frame_p       = 2048,
  parameter int err_count_width_p = 16
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic [7:0]                     s_axis_tdata_i,
  input  logic                           s_axis_tvalid_i,
  output logic                           s_axis_tready_o,
  input  logic                           s_axis_tlast_i,
  input  logic                           s_axis_tuser_i,
  output logic [data_width_p-1:0]        m_axis_tdata_o,
  output logic [data_width_p/8-1:0]      m_axis_tkeep_o,
  output logic                           m_axis_tvalid_o,
  input  logic                           m_axis_tready_i,
  output logic                           m_axis_tlast_o,
  output logic                           m_axis_tuser_o,
  output logic [err_count_width_p-1:0]   err_count_o
);

  localparam int n_lp     = data_width_p / 8;
  localparam int idx_w_lp = $clog2(n_lp);
  localparam int cnt_w_lp = $clog2(max_frame_p + 1);

  localparam logic [idx_w_lp-1:0] last_idx_lp = idx_w_lp'(n_lp - 1);
  localparam logic [cnt_w_lp-1:0] last_cnt_lp = cnt_w_lp'(max_frame_p - 1);

  typedef enum logic {ACCUM, DISCARD} state_e;

  state_e                         state_q, state_d;
  logic                           s_ready_q, s_ready_d;

  logic [data_width_p-1:0]        asm_data_q, asm_data_d;
  logic [n_lp-1:0]                asm_keep_q, asm_keep_d;
  logic [idx_w_lp-1:0]            asm_idx_q, asm_idx_d;
  logic                           asm_full_q, asm_full_d;
  logic                           asm_last_q, asm_last_d;
  logic                           asm_user_q, asm_user_d;

  logic [cnt_w_lp-1:0]            frame_cnt_q, frame_cnt_d;
  logic                           err_q, err_d;

  logic [data_width_p-1:0]        out_data_q, out_data_d;
  logic [n_lp-1:0]                out_keep_q, out_keep_d;
  logic                           out_valid_q, out_valid_d;
  logic                           out_last_q, out_last_d;
  logic                           out_user_q, out_user_d;

  logic [err_count_width_p-1:0]   err_cnt_q, err_cnt_d;

  logic                           s_fire;
  logic                           m_fire;
  logic                           out_free;
  logic [data_width_p-1:0]        wr_data;
  logic [n_lp-1:0]                wr_keep;
  logic                           at_max;
  logic                           trunc;
  logic                           word_last;
  logic                           word_user;
  logic                           complete;

  // Byte-lane merge of the incoming byte and the word-completion conditions.
  always_comb begin
    s_fire    = s_axis_tvalid_i & s_ready_q;
    m_fire    = out_valid_q & m_axis_tready_i;
    out_free  = ~out_valid_q | m_axis_tready_i;

    wr_data = asm_data_q;
    wr_data[{asm_idx_q, 3'b000} +: 8] = s_axis_tdata_i;
    wr_keep = asm_keep_q;
    wr_keep[asm_idx_q] = 1'b1;

    at_max    = (frame_cnt_q == last_cnt_lp);
    trunc     = at_max & ~s_axis_tlast_i;
    word_last = s_axis_tlast_i | at_max;
    word_user = word_last & (err_q | s_axis_tuser_i | trunc);
    complete  = (asm_idx_q == last_idx_lp) | word_last;
  end

  always_comb begin
    state_d     = state_q;
    asm_data_d  = asm_data_q;
    asm_keep_d  = asm_keep_q;
    asm_idx_d   = asm_idx_q;
    asm_full_d  = asm_full_q;
    asm_last_d  = asm_last_q;
    asm_user_d  = asm_user_q;
    frame_cnt_d = frame_cnt_q;
    err_d       = err_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    out_user_d  = out_user_q;
    out_valid_d = out_valid_q & ~m_fire;
    err_cnt_d   = err_cnt_q;

    if (asm_full_q) begin
      // A stalled word leaves assembly as soon as the output register frees.
      if (out_free) begin
        out_data_d  = asm_data_q;
        out_keep_d  = asm_keep_q;
        out_last_d  = asm_last_q;
        out_user_d  = asm_user_q;
        out_valid_d = 1'b1;
        asm_full_d  = 1'b0;
        asm_data_d  = '0;
        asm_keep_d  = '0;
        asm_last_d  = 1'b0;
        asm_user_d  = 1'b0;
      end
    end else if (state_q == ACCUM && s_fire) begin
      if (complete) begin
        asm_idx_d = '0;
        if (out_free) begin
          out_data_d  = wr_data;
          out_keep_d  = wr_keep;
          out_last_d  = word_last;
          out_user_d  = word_user;
          out_valid_d = 1'b1;
          asm_data_d  = '0;
          asm_keep_d  = '0;
        end else begin
          asm_full_d = 1'b1;
          asm_data_d = wr_data;
          asm_keep_d = wr_keep;
          asm_last_d = word_last;
          asm_user_d = word_user;
        end
      end else begin
        asm_data_d = wr_data;
        asm_keep_d = wr_keep;
        asm_idx_d  = asm_idx_q + idx_w_lp'(1);
      end

      if (word_last) begin
        frame_cnt_d = '0;
        err_d       = 1'b0;
      end else begin
        frame_cnt_d = frame_cnt_q + cnt_w_lp'(1);
        err_d       = err_q | s_axis_tuser_i;
      end

      if (trunc) begin
        state_d = DISCARD;
      end
    end

    // The tail of a truncated frame is swallowed up to and including its tlast byte.
    if (state_q == DISCARD && s_fire && s_axis_tlast_i) begin
      state_d = ACCUM;
    end

    s_ready_d = (state_d == DISCARD) | ~asm_full_d;

    if (m_fire && out_last_q && out_user_q && (err_cnt_q != {err_count_width_p{1'b1}})) begin
      err_cnt_d = err_cnt_q + err_count_width_p'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= ACCUM;
      s_ready_q   <= 1'b0;
      asm_data_q  <= '0;
      asm_keep_q  <= '0;
      asm_idx_q   <= '0;
      asm_full_q  <= 1'b0;
      asm_last_q  <= 1'b0;
      asm_user_q  <= 1'b0;
      frame_cnt_q <= '0;
      err_q       <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_user_q  <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      s_ready_q   <= s_ready_d;
      asm_data_q  <= asm_data_d;
      asm_keep_q  <= asm_keep_d;
      asm_idx_q   <= asm_idx_d;
      asm_full_q  <= asm_full_d;
      asm_last_q  <= asm_last_d;
      asm_user_q  <= asm_user_d;
      frame_cnt_q <= frame_cnt_d;
      err_q       <= err_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_user_q  <= out_user_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign s_axis_tready_o = s_ready_q;
  assign m_axis_tdata_o  = out_data_q;
  assign m_axis_tkeep_o  = out_keep_q;
  assign m_axis_tvalid_o = out_valid_q;
  assign m_axis_tlast_o  = out_last_q;
  assign m_axis_tuser_o  = out_user_q;
  assign err_count_o     = err_cnt_q;

endmodule

// File: tb/tb_eth_rx_axis_packer.sv
// Scoreboard bench for eth_rx_axis_packer: a 32-bit instance with a 16-byte frame limit
// and a 64-bit instance with the default limit, checked against hand-computed words.
module tb_eth_rx_axis_packer;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  logic [7:0]  a_s_tdata;
  logic        a_s_tvalid, a_s_tready, a_s_tlast, a_s_tuser;
  logic [31:0] a_m_tdata;
  logic [3:0]  a_m_tkeep;
  logic        a_m_tvalid, a_m_tready, a_m_tlast, a_m_tuser;
  logic [15:0] a_err_count;

  logic [7:0]  b_s_tdata;
  logic        b_s_tvalid, b_s_tready, b_s_tlast, b_s_tuser;
  logic [63:0] b_m_tdata;
  logic [7:0]  b_m_tkeep;
  logic        b_m_tvalid, b_m_tready, b_m_tlast, b_m_tuser;
  logic [15:0] b_err_count;

  int   checks = 0;
  int   failures = 0;
  exp_t qa[$];
  exp_t qb[$];

  eth_rx_axis_packer #(.data_width_p(32), .max_frame_p(16), .err_count_width_p(16)) dut_a (
    .clk_i(clk), .reset_n_i(reset_n),
    .s_axis_tdata_i(a_s_tdata), .s_axis_tvalid_i(a_s_tvalid), .s_axis_tready_o(a_s_tready),
    .s_axis_tlast_i(a_s_tlast), .s_axis_tuser_i(a_s_tuser),
    .m_axis_tdata_o(a_m_tdata), .m_axis_tkeep_o(a_m_tkeep), .m_axis_tvalid_o(a_m_tvalid),
    .m_axis_tready_i(a_m_tready), .m_axis_tlast_o(a_m_tlast), .m_axis_tuser_o(a_m_tuser),
    .err_count_o(a_err_count)
  );

  eth_rx_axis_packer #(.data_width_p(64), .max_frame_p(2048), .err_count_width_p(16)) dut_b (
    .clk_i(clk), .reset_n_i(reset_n),
    .s_axis_tdata_i(b_s_tdata), .s_axis_tvalid_i(b_s_tvalid), .s_axis_tready_o(b_s_tready),
    .s_axis_tlast_i(b_s_tlast), .s_axis_tuser_i(b_s_tuser),
    .m_axis_tdata_o(b_m_tdata), .m_axis_tkeep_o(b_m_tkeep), .m_axis_tvalid_o(b_m_tvalid),
    .m_axis_tready_i(b_m_tready), .m_axis_tlast_o(b_m_tlast), .m_axis_tuser_o(b_m_tuser),
    .err_count_o(b_err_count)
  );

  task automatic checkOutput(input string name, input logic [79:0] act, input logic [79:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitors: pop the next expected word on every output handshake.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (reset_n && a_m_tvalid && a_m_tready) begin
      if (qa.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL a_unexpected_word actual=0x%0h required=none", a_m_tdata);
      end else begin
        e = qa.pop_front();
        checkOutput("a_word", {32'h0, a_m_tdata, 4'h0, a_m_tkeep, 6'h0, a_m_tlast, a_m_tuser},
                    {e.data, e.keep, 6'h0, e.last, e.user});
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (reset_n && b_m_tvalid && b_m_tready) begin
      if (qb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL b_unexpected_word actual=0x%0h required=none", b_m_tdata);
      end else begin
        e = qb.pop_front();
        checkOutput("b_word", {b_m_tdata, b_m_tkeep, 6'h0, b_m_tlast, b_m_tuser},
                    {e.data, e.keep, 6'h0, e.last, e.user});
      end
    end
  end

  task automatic pushExp(input int sel, input logic [63:0] data, input logic [7:0] keep,
                         input logic last, input logic user);
    exp_t e;
    e.data = data;
    e.keep = keep;
    e.last = last;
    e.user = user;
    if (sel == 0) qa.push_back(e);
    else qb.push_back(e);
  endtask

  // Offer one byte and hold it until the selected DUT accepts it.
  task automatic applyStimulus(input int sel, input logic [7:0] b, input logic last, input logic user);
    logic accepted;
    int   waited;
    accepted = 1'b0;
    waited   = 0;
    if (sel == 0) begin
      a_s_tdata = b; a_s_tlast = last; a_s_tuser = user; a_s_tvalid = 1'b1;
    end else begin
      b_s_tdata = b; b_s_tlast = last; b_s_tuser = user; b_s_tvalid = 1'b1;
    end
    while (!accepted && waited < 200) begin
      @(negedge clk);
      accepted = (sel == 0) ? a_s_tready : b_s_tready;
      @(posedge clk);
      #1;
      waited++;
    end
    if (sel == 0) a_s_tvalid = 1'b0;
    else b_s_tvalid = 1'b0;
    if (!accepted) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout actual=not_accepted required=accepted byte=0x%0h", b);
    end
  endtask

  task automatic sendSeq(input int sel, input logic [7:0] first, input int len,
                         input logic with_last, input int err_pos);
    for (int i = 0; i < len; i++) begin
      applyStimulus(sel, first + 8'(i), with_last && (i == len - 1), (i + 1) == err_pos);
    end
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 100 && (qa.size() != 0 || qb.size() != 0); i++) begin
      @(posedge clk);
      #1;
    end
    repeat (2) @(posedge clk);
    #1;
    checkOutput("drain_pending", 80'(qa.size() + qb.size()), 80'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    a_s_tdata = '0; a_s_tvalid = 1'b0; a_s_tlast = 1'b0; a_s_tuser = 1'b0; a_m_tready = 1'b1;
    b_s_tdata = '0; b_s_tvalid = 1'b0; b_s_tlast = 1'b0; b_s_tuser = 1'b0; b_m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_state_a", {a_m_tdata, a_m_tkeep, a_m_tvalid, a_m_tlast, a_m_tuser, a_s_tready, a_err_count},
                80'h0);
    checkOutput("reset_state_b", {b_m_tvalid, b_s_tready, b_err_count}, 80'h0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] 9-byte frame, full rate");
    pushExp(0, 64'h04030201, 8'hF, 1'b0, 1'b0);
    pushExp(0, 64'h08070605, 8'hF, 1'b0, 1'b0);
    pushExp(0, 64'h00000009, 8'h1, 1'b1, 1'b0);
    sendSeq(0, 8'h01, 3, 1'b0, 0);
    checkOutput("tvalid_before_word", 80'(a_m_tvalid), 80'd0);
    sendSeq(0, 8'h04, 1, 1'b0, 0);
    checkOutput("tvalid_latency", 80'(a_m_tvalid), 80'd1);
    sendSeq(0, 8'h05, 5, 1'b1, 0);
    waitDrain();

    $display("[TB] 8-byte frame with downstream stalled");
    a_m_tready = 1'b0;
    pushExp(0, 64'h04030201, 8'hF, 1'b0, 1'b0);
    pushExp(0, 64'h08070605, 8'hF, 1'b1, 1'b0);
    sendSeq(0, 8'h01, 8, 1'b1, 0);
    checkOutput("stall_s_tready", 80'(a_s_tready), 80'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("stall_hold", {a_m_tdata, a_m_tvalid, a_s_tready}, {48'h0, 32'h04030201, 1'b1, 1'b0});
    a_m_tready = 1'b1;
    waitDrain();

    $display("[TB] 6-byte frame with MAC error on byte 3");
    checkOutput("err_count_before", 80'(a_err_count), 80'd0);
    pushExp(0, 64'h04030201, 8'hF, 1'b0, 1'b0);
    pushExp(0, 64'h00000605, 8'h3, 1'b1, 1'b1);
    sendSeq(0, 8'h01, 6, 1'b1, 3);
    waitDrain();
    checkOutput("err_count_after", 80'(a_err_count), 80'd1);

    $display("[TB] reset mid-frame");
    a_m_tready = 1'b0;
    sendSeq(0, 8'h31, 7, 1'b0, 0);
    checkOutput("pre_reset_tvalid", 80'(a_m_tvalid), 80'd1);
    reset_n = 1'b0;
    #2;
    checkOutput("async_reset", {a_m_tvalid, a_s_tready, a_err_count}, 80'h0);
    qa.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    a_m_tready = 1'b1;
    pushExp(0, 64'hA4A3A2A1, 8'hF, 1'b1, 1'b0);
    sendSeq(0, 8'hA1, 4, 1'b1, 0);
    waitDrain();

    $display("[TB] 20-byte oversize frame then 5-byte frame");
    pushExp(0, 64'h04030201, 8'hF, 1'b0, 1'b0);
    pushExp(0, 64'h08070605, 8'hF, 1'b0, 1'b0);
    pushExp(0, 64'h0C0B0A09, 8'hF, 1'b0, 1'b0);
    pushExp(0, 64'h100F0E0D, 8'hF, 1'b1, 1'b1);
    pushExp(0, 64'h24232221, 8'hF, 1'b0, 1'b0);
    pushExp(0, 64'h00000025, 8'h1, 1'b1, 1'b0);
    sendSeq(0, 8'h01, 20, 1'b1, 0);
    sendSeq(0, 8'h21, 5, 1'b1, 0);
    waitDrain();
    checkOutput("err_count_trunc", 80'(a_err_count), 80'd1);

    $display("[TB] 64-bit 1-byte frame");
    pushExp(1, 64'h000000000000005A, 8'h01, 1'b1, 1'b0);
    sendSeq(1, 8'h5A, 1, 1'b1, 0);
    waitDrain();
    checkOutput("b_err_count", 80'(b_err_count), 80'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
